// File: rtl/sys_ctrl.sv
// Command sequencer between a UART byte stream, a register file and an ALU.
// Decodes write/read/ALU commands and pushes single-byte responses to the TX FIFO.
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
    input  logic                  RF_RD_DATA_VLD,
    input  logic                  TX_FULL,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic [ADDR_WIDTH-1:0] RF_ADDR,
    output logic                  RF_WR_EN,
    output logic                  RF_RD_EN,
    output logic [DATA_WIDTH-1:0] RF_WR_DATA,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
        OP_A, OP_B, FUN, ALU_WAIT, TX_SEND
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
    logic [DATA_WIDTH-1:0] tx_byte, tx_byte_nx;

    logic                  alu_en_nx;
    logic [FUN_WIDTH-1:0]  alu_fun_nx;
    logic [ADDR_WIDTH-1:0] rf_addr_nx;
    logic                  rf_wr_en_nx;
    logic                  rf_rd_en_nx;
    logic [DATA_WIDTH-1:0] rf_wr_data_nx;
    logic [DATA_WIDTH-1:0] tx_p_data_nx;
    logic                  tx_d_vld_nx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            tx_byte    <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            RF_ADDR    <= '0;
            RF_WR_EN   <= 1'b0;
            RF_RD_EN   <= 1'b0;
            RF_WR_DATA <= '0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
        end else begin
            state      <= state_nx;
            addr_q     <= addr_nx;
            tx_byte    <= tx_byte_nx;
            ALU_EN     <= alu_en_nx;
            ALU_FUN    <= alu_fun_nx;
            RF_ADDR    <= rf_addr_nx;
            RF_WR_EN   <= rf_wr_en_nx;
            RF_RD_EN   <= rf_rd_en_nx;
            RF_WR_DATA <= rf_wr_data_nx;
            TX_P_DATA  <= tx_p_data_nx;
            TX_D_VLD   <= tx_d_vld_nx;
        end
    end

    // Outputs are registered from their *_nx values, so every strobe appears
    // the cycle after the byte or handshake that triggers it. Strobes come
    // from distinct states, which keeps them mutually exclusive by design.
    always_comb begin
        state_nx      = state;
        addr_nx       = addr_q;
        tx_byte_nx    = tx_byte;
        alu_en_nx     = 1'b0;
        alu_fun_nx    = ALU_FUN;
        rf_addr_nx    = RF_ADDR;
        rf_wr_en_nx   = 1'b0;
        rf_rd_en_nx   = 1'b0;
        rf_wr_data_nx = RF_WR_DATA;
        tx_p_data_nx  = TX_P_DATA;
        tx_d_vld_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_nx = WR_ADDR;
                        CMD_RD:     state_nx = RD_ADDR;
                        CMD_ALU_OP: state_nx = OP_A;
                        CMD_ALU:    state_nx = FUN;
                        default:    state_nx = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nx = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    rf_wr_en_nx   = 1'b1;
                    rf_addr_nx    = addr_q;
                    rf_wr_data_nx = RX_P_DATA;
                    state_nx      = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rf_rd_en_nx = 1'b1;
                    rf_addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nx    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RF_RD_DATA_VLD) begin
                    tx_byte_nx = RF_RD_DATA;
                    state_nx   = TX_SEND;
                end
            end
            // Operands land in the two lowest register-file locations.
            OP_A: begin
                if (RX_D_VLD) begin
                    rf_wr_en_nx   = 1'b1;
                    rf_addr_nx    = '0;
                    rf_wr_data_nx = RX_P_DATA;
                    state_nx      = OP_B;
                end
            end
            OP_B: begin
                if (RX_D_VLD) begin
                    rf_wr_en_nx   = 1'b1;
                    rf_addr_nx    = ADDR_WIDTH'(1);
                    rf_wr_data_nx = RX_P_DATA;
                    state_nx      = FUN;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    alu_en_nx  = 1'b1;
                    alu_fun_nx = RX_P_DATA[FUN_WIDTH-1:0];
                    state_nx   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    tx_byte_nx = ALU_OUT;
                    state_nx   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!TX_FULL) begin
                    tx_d_vld_nx  = 1'b1;
                    tx_p_data_nx = tx_byte;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: write, read, ALU, backpressure, illegal byte
// and mid-command reset scenarios with hand-computed expectations.
module tb_sys_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] ALU_OUT = '0;
    logic       ALU_OUT_VLD = 1'b0;
    logic [7:0] RF_RD_DATA = '0;
    logic       RF_RD_DATA_VLD = 1'b0;
    logic       TX_FULL = 1'b0;
    logic       ALU_EN;
    logic [3:0] ALU_FUN;
    logic [3:0] RF_ADDR;
    logic       RF_WR_EN;
    logic       RF_RD_EN;
    logic [7:0] RF_WR_DATA;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;

    sys_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
        .TX_FULL(TX_FULL),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .RF_ADDR(RF_ADDR),
        .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN), .RF_WR_DATA(RF_WR_DATA),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse log, sampled shortly after each rising edge.
    int         wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, tx_cnt = 0, excl_viol = 0;
    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    always @(posedge CLK) begin
        #2;
        if (RF_WR_EN) begin
            wr_cnt++;
            wr_addr_q.push_back(RF_ADDR);
            wr_data_q.push_back(RF_WR_DATA);
        end
        if (RF_RD_EN) rd_cnt++;
        if (ALU_EN)   alu_cnt++;
        if (TX_D_VLD) tx_cnt++;
        if ((int'(RF_WR_EN) + int'(RF_RD_EN) + int'(ALU_EN) + int'(TX_D_VLD)) > 1)
            excl_viol++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Waits up to 'budget' negedges for a TX push and captures its byte.
    task automatic wait_tx(input int budget, output logic got, output logic [7:0] data);
        got  = 1'b0;
        data = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (TX_D_VLD === 1'b1) begin
                got  = 1'b1;
                data = TX_P_DATA;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [32:0] outs;
        #1;
        outs = {ALU_EN, ALU_FUN, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD};
        n_checks++;
        if (outs !== 33'd0) $display("FAIL reset_outputs: got %h want 0", outs);
        else n_pass++;
        idle_cycles(2);
        RST = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_write;
        int wb = wr_cnt, tb = tx_cnt;
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        n_checks++;
        if (RF_WR_EN !== 1'b1) $display("FAIL wr_strobe: got %b want 1", RF_WR_EN);
        else n_pass++;
        n_checks++;
        if (RF_ADDR !== 4'h5) $display("FAIL wr_addr: got %h want 5", RF_ADDR);
        else n_pass++;
        n_checks++;
        if (RF_WR_DATA !== 8'h3C) $display("FAIL wr_data: got %h want 3c", RF_WR_DATA);
        else n_pass++;
        idle_cycles(4);
        n_checks++;
        if (wr_cnt - wb !== 1) $display("FAIL wr_pulse_count: got %0d want 1", wr_cnt - wb);
        else n_pass++;
        n_checks++;
        if (tx_cnt - tb !== 0) $display("FAIL wr_no_tx: got %0d want 0", tx_cnt - tb);
        else n_pass++;
    endtask

    task automatic test_read;
        int rb = rd_cnt, tb = tx_cnt;
        logic got;
        logic [7:0] d;
        send_byte(8'hBB); send_byte(8'h05);
        n_checks++;
        if (RF_RD_EN !== 1'b1 || RF_ADDR !== 4'h5)
            $display("FAIL rd_strobe: got en=%b addr=%h want en=1 addr=5", RF_RD_EN, RF_ADDR);
        else n_pass++;
        @(negedge CLK);
        RF_RD_DATA = 8'h3C; RF_RD_DATA_VLD = 1'b1;
        @(negedge CLK);
        RF_RD_DATA_VLD = 1'b0; RF_RD_DATA = 8'h00;
        wait_tx(10, got, d);
        n_checks++;
        if (got !== 1'b1 || d !== 8'h3C) $display("FAIL rd_tx: got vld=%b data=%h want vld=1 data=3c", got, d);
        else n_pass++;
        idle_cycles(3);
        n_checks++;
        if (rd_cnt - rb !== 1 || tx_cnt - tb !== 1)
            $display("FAIL rd_counts: got rd=%0d tx=%0d want rd=1 tx=1", rd_cnt - rb, tx_cnt - tb);
        else n_pass++;
    endtask

    task automatic test_alu_operands;
        int wb = wr_cnt, ab = alu_cnt;
        logic got;
        logic [7:0] d;
        send_byte(8'hCC); send_byte(8'h07); send_byte(8'h03); send_byte(8'h00);
        n_checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h0)
            $display("FAIL alu_en: got en=%b fun=%h want en=1 fun=0", ALU_EN, ALU_FUN);
        else n_pass++;
        @(negedge CLK);
        ALU_OUT = 8'h0A; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0; ALU_OUT = 8'h00;
        wait_tx(10, got, d);
        n_checks++;
        if (got !== 1'b1 || d !== 8'h0A) $display("FAIL alu_tx: got vld=%b data=%h want vld=1 data=0a", got, d);
        else n_pass++;
        idle_cycles(2);
        n_checks++;
        if (wr_cnt - wb !== 2) $display("FAIL op_wr_count: got %0d want 2", wr_cnt - wb);
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr_q[wb] !== 4'h0 || wr_data_q[wb] !== 8'h07 ||
                wr_addr_q[wb+1] !== 4'h1 || wr_data_q[wb+1] !== 8'h03)
                $display("FAIL op_wr_values: got (%h,%h),(%h,%h) want (0,07),(1,03)",
                         wr_addr_q[wb], wr_data_q[wb], wr_addr_q[wb+1], wr_data_q[wb+1]);
            else n_pass++;
        end
        n_checks++;
        if (alu_cnt - ab !== 1) $display("FAIL alu_pulse_count: got %0d want 1", alu_cnt - ab);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int tb = tx_cnt;
        TX_FULL = 1'b1;
        send_byte(8'hDD); send_byte(8'h02);
        n_checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h2)
            $display("FAIL bp_alu_en: got en=%b fun=%h want en=1 fun=2", ALU_EN, ALU_FUN);
        else n_pass++;
        @(negedge CLK);
        ALU_OUT = 8'h5E; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0; ALU_OUT = 8'h00;
        idle_cycles(4);
        n_checks++;
        if (tx_cnt - tb !== 0 || TX_D_VLD !== 1'b0)
            $display("FAIL bp_hold: got pushes=%0d want 0", tx_cnt - tb);
        else n_pass++;
        TX_FULL = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h5E)
            $display("FAIL bp_release: got vld=%b data=%h want vld=1 data=5e", TX_D_VLD, TX_P_DATA);
        else n_pass++;
        idle_cycles(3);
        n_checks++;
        if (tx_cnt - tb !== 1) $display("FAIL bp_single_push: got %0d want 1", tx_cnt - tb);
        else n_pass++;
        n_checks++;
        if (ALU_FUN !== 4'h2) $display("FAIL alu_fun_held: got %h want 2", ALU_FUN);
        else n_pass++;
    endtask

    task automatic test_ignored_inputs;
        int tb = tx_cnt, wb = wr_cnt, rb = rd_cnt, ab = alu_cnt;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b1; RF_RD_DATA_VLD = 1'b1; ALU_OUT = 8'h99; RF_RD_DATA = 8'h98;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0; RF_RD_DATA_VLD = 1'b0;
        send_byte(8'h55);
        idle_cycles(4);
        n_checks++;
        if (tx_cnt - tb + wr_cnt - wb + rd_cnt - rb + alu_cnt - ab !== 0)
            $display("FAIL idle_quiet: got %0d strobes want 0", tx_cnt - tb + wr_cnt - wb + rd_cnt - rb + alu_cnt - ab);
        else n_pass++;
    endtask

    task automatic test_abort;
        int wb = wr_cnt;
        logic [32:0] outs;
        logic got;
        logic [7:0] d;
        send_byte(8'hAA); send_byte(8'h02);
        @(negedge CLK);
        RX_P_DATA = 8'h66; RX_D_VLD = 1'b1;
        #1 RST = 1'b0;
        #1;
        outs = {ALU_EN, ALU_FUN, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, TX_P_DATA, TX_D_VLD};
        n_checks++;
        if (outs !== 33'd0) $display("FAIL abort_outputs: got %h want 0", outs);
        else n_pass++;
        @(negedge CLK);
        RX_D_VLD = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        idle_cycles(2);
        n_checks++;
        if (wr_cnt - wb !== 0) $display("FAIL abort_no_write: got %0d want 0", wr_cnt - wb);
        else n_pass++;
        send_byte(8'hBB); send_byte(8'h02);
        n_checks++;
        if (RF_RD_EN !== 1'b1 || RF_ADDR !== 4'h2)
            $display("FAIL post_reset_read: got en=%b addr=%h want en=1 addr=2", RF_RD_EN, RF_ADDR);
        else n_pass++;
        @(negedge CLK);
        RF_RD_DATA = 8'h77; RF_RD_DATA_VLD = 1'b1;
        @(negedge CLK);
        RF_RD_DATA_VLD = 1'b0;
        wait_tx(10, got, d);
        n_checks++;
        if (got !== 1'b1 || d !== 8'h77) $display("FAIL post_reset_tx: got vld=%b data=%h want vld=1 data=77", got, d);
        else n_pass++;
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        int wb = wr_cnt;
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'hE1);
        send_byte(8'hAA); send_byte(8'h19); send_byte(8'h42);
        idle_cycles(3);
        n_checks++;
        if (wr_cnt - wb !== 2) $display("FAIL b2b_count: got %0d want 2", wr_cnt - wb);
        else begin
            n_pass++;
            n_checks++;
            if (wr_addr_q[wb] !== 4'hF || wr_data_q[wb] !== 8'hE1 ||
                wr_addr_q[wb+1] !== 4'h9 || wr_data_q[wb+1] !== 8'h42)
                $display("FAIL b2b_values: got (%h,%h),(%h,%h) want (f,e1),(9,42)",
                         wr_addr_q[wb], wr_data_q[wb], wr_addr_q[wb+1], wr_data_q[wb+1]);
            else n_pass++;
        end
        n_checks++;
        if (excl_viol !== 0) $display("FAIL strobe_exclusive: got %0d overlaps want 0", excl_viol);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_alu_operands;
        test_backpressure;
        test_ignored_inputs;
        test_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
